// File: rtl/seq_unsigned_divider.sv
// Multi-cycle restoring unsigned divider: quotient = a / b, remainder = a % b.
// It processes ceil(a_width/num_cyc) quotient bits per cycle, so a result is
// ready exactly num_cyc cycles after start (plus one cycle per held cycle).
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   hold         - freeze an in-progress division (ignored when idle)
//   start        - begin a division; a and b are sampled on this edge
//   a, b         - unsigned dividend / divisor
//   complete     - 1 = results valid / idle, 0 = division in progress
//   divide_by_0  - b was zero for the current result
//   quotient     - registered quotient (all ones on divide by zero)
//   remainder    - registered remainder (a[b_width-1:0] on divide by zero)
module seq_unsigned_divider #(
  parameter int unsigned a_width = 8,
  parameter int unsigned b_width = 8,
  parameter int unsigned num_cyc = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic               start,
  input  logic [a_width-1:0] a,
  input  logic [b_width-1:0] b,
  output logic               complete,
  output logic               divide_by_0,
  output logic [a_width-1:0] quotient,
  output logic [b_width-1:0] remainder
);

  // Bits per step; the dividend is zero-extended to a whole number of steps
  // so the final step absorbs any leftover bits without special casing.
  localparam int unsigned BPS = (a_width + num_cyc - 1) / num_cyc;
  localparam int unsigned TW  = BPS * num_cyc;
  localparam int unsigned CW  = $clog2(num_cyc);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [TW-1:0]      work;
  logic [a_width-1:0] q_work;
  logic [b_width-1:0] rem;
  logic [b_width-1:0] b_reg;
  logic [b_width-1:0] a_low;

  logic [TW-1:0]      work_nxt;
  logic [a_width-1:0] q_nxt;
  logic [b_width-1:0] rem_nxt;
  logic [b_width:0]   sh;

  // One step of BPS restoring shift-subtract iterations, MSB first.
  always_comb begin
    work_nxt = work;
    q_nxt    = q_work;
    rem_nxt  = rem;
    sh       = '0;
    for (int i = 0; i < int'(BPS); i++) begin
      sh       = {rem_nxt, work_nxt[TW-1]};
      work_nxt = work_nxt << 1;
      if (sh >= {1'b0, b_reg}) begin
        sh    = sh - {1'b0, b_reg};
        q_nxt = {q_nxt[a_width-2:0], 1'b1};
      end else begin
        q_nxt = {q_nxt[a_width-2:0], 1'b0};
      end
      // With b != 0 the difference is < b; with b == 0 the value is discarded.
      rem_nxt = sh[b_width-1:0];
    end
  end

  // Control and datapath registers; start overrides hold and any running division.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      work        <= '0;
      q_work      <= '0;
      rem         <= '0;
      b_reg       <= '0;
      a_low       <= '0;
      complete    <= 1'b0;
      divide_by_0 <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else if (start) begin
      state    <= BUSY;
      cnt      <= '0;
      work     <= TW'(a);
      q_work   <= '0;
      rem      <= '0;
      b_reg    <= b;
      a_low    <= a[b_width-1:0];
      complete <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          if (!hold) begin
            work   <= work_nxt;
            q_work <= q_nxt;
            rem    <= rem_nxt;
            if (cnt == CW'(num_cyc - 1)) begin
              state    <= IDLE;
              cnt      <= '0;
              complete <= 1'b1;
              if (b_reg == '0) begin
                divide_by_0 <= 1'b1;
                quotient    <= '1;
                remainder   <= a_low;
              end else begin
                divide_by_0 <= 1'b0;
                quotient    <= q_nxt;
                remainder   <= rem_nxt;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// Scoreboard bench for seq_unsigned_divider with a_width=8, b_width=5, num_cyc=3.
module tb_seq_unsigned_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [4:0] b = '0;
  logic       complete;
  logic       divide_by_0;
  logic [7:0] quotient;
  logic [4:0] remainder;

  seq_unsigned_divider #(.a_width(8), .b_width(5), .num_cyc(3)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .start(start), .a(a), .b(b),
    .complete(complete), .divide_by_0(divide_by_0),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [4:0] r;
    logic       dz;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   t0;

  // Model of what the outputs must hold between completions.
  logic [7:0] last_q = '0;
  logic [4:0] last_r = '0;
  logic       last_dz = 1'b0;
  logic       prev_c = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare on each rising edge of complete; otherwise outputs must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_c  = 1'b0;
      last_q  = '0;
      last_r  = '0;
      last_dz = 1'b0;
    end else begin
      if (complete && !prev_c) begin
        if (sb.size() == 0) begin
          check("unexpected_complete", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("latency_cycle", cyc, e.cyc);
          check("quotient", int'(quotient), int'(e.q));
          check("remainder", int'(remainder), int'(e.r));
          check("divide_by_0", int'(divide_by_0), int'(e.dz));
          last_q  = e.q;
          last_r  = e.r;
          last_dz = e.dz;
        end
      end else if (!complete) begin
        check("outputs_stable_while_busy",
              int'({divide_by_0, remainder, quotient}),
              int'({last_dz, last_r, last_q}));
      end
      prev_c = complete;
    end
  end

  // Pulse start with the given operands; optionally push an expectation.
  task automatic start_op(input logic [7:0] av, input logic [4:0] bv, input bit push,
                          input logic [7:0] eq, input logic [4:0] er, input logic edz,
                          input int extra);
    exp_t e;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    a = 8'hA5;
    b = 5'h13;
    if (push) begin
      e.q = eq; e.r = er; e.dz = edz; e.cyc = t0 + 3 + extra;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("completion_timeout", 0, 1);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'({complete, divide_by_0, remainder, quotient}), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_complete_after_reset", int'(complete), 0);

    start_op(8'd50, 5'd24, 1, 8'd2, 5'd2, 1'b0, 0);   wait_drain();
    start_op(8'd48, 5'd24, 1, 8'd2, 5'd0, 1'b0, 0);   wait_drain();
    start_op(8'd5, 5'd24, 1, 8'd0, 5'd5, 1'b0, 0);    wait_drain();
    start_op(8'd255, 5'd1, 1, 8'd255, 5'd0, 1'b0, 0); wait_drain();
    start_op(8'd255, 5'd31, 1, 8'd8, 5'd7, 1'b0, 0);  wait_drain();
    start_op(8'd200, 5'd0, 1, 8'd255, 5'd8, 1'b1, 0); wait_drain();
    start_op(8'd9, 5'd3, 1, 8'd3, 5'd0, 1'b0, 0);     wait_drain();

    // Hold for two cycles mid-division: completion slips by two.
    start_op(8'd100, 5'd7, 1, 8'd14, 5'd2, 1'b0, 2);
    @(posedge clk);
    #1 hold = 1'b1;
    repeat (2) @(posedge clk);
    #1 hold = 1'b0;
    wait_drain();

    // Hold while idle must not disturb anything.
    hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold_complete", int'(complete), 1);
    check("idle_hold_quotient", int'(quotient), 14);
    hold = 1'b0;

    // Restart one cycle after the first start: only the second result appears.
    start_op(8'd100, 5'd7, 0, 8'd0, 5'd0, 1'b0, 0);
    start_op(8'd30, 5'd4, 1, 8'd7, 5'd2, 1'b0, 0);
    wait_drain();

    // Asynchronous reset mid-division.
    start_op(8'd100, 5'd7, 0, 8'd0, 5'd0, 1'b0, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({complete, divide_by_0, remainder, quotient}), 0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_complete_after_abort", int'(complete), 0);
    start_op(8'd24, 5'd24, 1, 8'd1, 5'd0, 1'b0, 0);
    wait_drain();

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
